// File: rtl/wavelet_readout_rx.sv
// Receive end of the wavelet core readout: decodes fb+/fb- codes per sample, integrates them over
// a WIN-sample window and hands each signed I/Q window sum out through a one-entry buffer.
module wavelet_readout_rx #(
    parameter int unsigned WIN   = 256,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             ud_en,
    input  logic             sample_en,
    input  logic             clr,
    input  logic [1:0]       read_out_I,
    input  logic [1:0]       read_out_Q,
    output logic [ACC_W-1:0] out_I,
    output logic [ACC_W-1:0] out_Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             win_done,
    output logic             overrun,
    output logic             code_err
);

    typedef enum logic {StEmpty, StFull} buf_state_t;

    buf_state_t              buf_state;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] dec_i;
    logic signed [ACC_W-1:0] dec_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0]        win_cnt;
    logic                    accept;
    logic                    last;
    logic                    illegal;

    // 2'b11 (both pulses at once) contributes nothing; it is only flagged.
    function automatic logic signed [ACC_W-1:0] decode(input logic [1:0] code);
        case (code)
            2'b01:   decode = {{(ACC_W-1){1'b0}}, 1'b1};
            2'b10:   decode = {ACC_W{1'b1}};
            default: decode = '0;
        endcase
    endfunction

    always_comb begin
        dec_i   = decode(read_out_I);
        dec_q   = decode(read_out_Q);
        sum_i   = acc_i + dec_i;
        sum_q   = acc_q + dec_q;
        accept  = ud_en & sample_en & ~clr;
        last    = accept & (win_cnt == CNT_W'(WIN - 1));
        illegal = accept & ((read_out_I == 2'b11) | (read_out_Q == 2'b11));
    end

    // Window integrator: the final sample's sum goes straight to the buffer, so the
    // accumulators restart at zero on that same edge and no sample is lost between windows.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            acc_i   <= '0;
            acc_q   <= '0;
            win_cnt <= '0;
        end else if (clr) begin
            acc_i   <= '0;
            acc_q   <= '0;
            win_cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc_i   <= '0;
                acc_q   <= '0;
                win_cnt <= '0;
            end else begin
                acc_i   <= sum_i;
                acc_q   <= sum_q;
                win_cnt <= win_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            win_done <= 1'b0;
            code_err <= 1'b0;
        end else begin
            win_done <= last;
            if (clr) begin
                code_err <= 1'b0;
            end else if (illegal) begin
                code_err <= 1'b1;
            end
        end
    end

    // Output buffer: a result arriving while full is only taken if the old one leaves on
    // the same edge; otherwise it is dropped and overrun latches.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            buf_state <= StEmpty;
            out_I     <= '0;
            out_Q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            buf_state <= StEmpty;
            out_I     <= '0;
            out_Q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (buf_state)
                StEmpty: begin
                    if (last) begin
                        buf_state <= StFull;
                        out_I     <= sum_i;
                        out_Q     <= sum_q;
                        out_valid <= 1'b1;
                    end
                end
                StFull: begin
                    if (last) begin
                        if (out_ready) begin
                            out_I <= sum_i;
                            out_Q <= sum_q;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        buf_state <= StEmpty;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    buf_state <= StEmpty;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
